// File: rtl/ctrl_link_tx.sv
// ctrl_link_tx -- serial transmitter carrying the local button state to a
// remote board.
//
// Each frame is: start bit (0), L, U, R data bits (LSB first), an optional
// even-parity bit, then a stop bit (1). After the stop bit the line idles high
// for GAP_BITS bit periods before a new frame can begin. The buttons are
// sampled once, on the edge that leaves IDLE, so the whole frame is consistent.
//
// Configuration macro: LINK_PARITY_EN
//   defined   -> start, L, U, R, parity, stop (6 bit periods)
//   undefined -> start, L, U, R, stop          (5 bit periods)
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit period (>= 2)
//   GAP_BITS      idle-high bit periods after each stop bit (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   BtnL/U/R    local button levels (already synchronised)
//   tx_en       allows a new frame to start while high
//   tx          registered serial output, idle high
//   busy        high from first start-bit cycle through last stop-bit cycle
//   frame_sent  one-cycle pulse on the last stop-bit cycle
//   frame_cnt   completed-frame counter, wraps 255 -> 0

module ctrl_link_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int GAP_BITS     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BtnL,
    input  logic       BtnU,
    input  logic       BtnR,
    input  logic       tx_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_sent,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } state_t;

    localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    // The gap is the longest interval timed by the shared counter.
    localparam int CNT_W      = $clog2(GAP_CYCLES);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [1:0]        idx, idx_next;
    logic [2:0]        snap, snap_next;   // {R, U, L}
    logic              tx_q, tx_next;
    logic [7:0]        frame_cnt_q;
    logic              bit_end;
    logic              frame_done;
    logic              data_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            snap        <= '0;
            tx_q        <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            snap  <= snap_next;
            tx_q  <= tx_next;
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        snap_next  = snap;
        frame_done = 1'b0;
        bit_end    = (cnt == BIT_LAST);

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (tx_en) begin
                    state_next = START;
                    snap_next  = {BtnR, BtnU, BtnL};
                    idx_next   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (idx == 2'd2) begin
`ifdef LINK_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx + 2'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    cnt_next   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    frame_done = 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // The line level is computed from the *next* state so the tx flop changes
    // on the same edge as the state register and only at bit boundaries.
    always_comb begin
        case (idx_next)
            2'd0:    data_bit = snap_next[0];
            2'd1:    data_bit = snap_next[1];
            default: data_bit = snap_next[2];
        endcase
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_bit;
            PARITY:  tx_next = ^snap_next;
            default: tx_next = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state == START) || (state == DATA) ||
                        (state == PARITY) || (state == STOP);
    assign frame_sent = frame_done;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ctrl_link_tx.sv
// Directed bench for ctrl_link_tx with CLKS_PER_BIT=4, GAP_BITS=2.
// Adapts the expected frame length to LINK_PARITY_EN.

module tb_ctrl_link_tx;

    localparam int CPB = 4;
    localparam int GB  = 2;
`ifdef LINK_PARITY_EN
    localparam int NB  = 6;
`else
    localparam int NB  = 5;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       BtnL, BtnU, BtnR;
    logic       tx_en;
    logic       tx;
    logic       busy;
    logic       frame_sent;
    logic [7:0] frame_cnt;

    int total  = 0;
    int passed = 0;

    ctrl_link_tx #(
        .CLKS_PER_BIT(CPB),
        .GAP_BITS    (GB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .BtnL      (BtnL),
        .BtnU      (BtnU),
        .BtnR      (BtnR),
        .tx_en     (tx_en),
        .tx        (tx),
        .busy      (busy),
        .frame_sent(frame_sent),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected line level for bit period p of a frame carrying rul = {R,U,L}.
    function automatic int exp_bit(input logic [2:0] rul, input int p);
        if (p == 0) return 0;
        if (p <= 3) return int'(rul[p-1]);
        if (p == NB - 1) return 1;
        return int'(^rul);
    endfunction

    // Checks one whole frame starting at the first START sample.
    // After the sample at cycle chg the buttons are zeroed; at cycle drop tx_en falls.
    task automatic frame_check(input logic [2:0] rul, input int chg, input int drop);
        for (int c = 0; c < NB * CPB; c++) begin
            @(negedge clk);
            check("frame_tx", int'(tx), exp_bit(rul, c / CPB));
            check("frame_busy", int'(busy), 1);
            check("frame_sent", int'(frame_sent), (c == NB * CPB - 1) ? 1 : 0);
            if (c == chg) begin
                BtnL = 1'b0; BtnU = 1'b0; BtnR = 1'b0;
            end
            if (c == drop) tx_en = 1'b0;
        end
    endtask

    task automatic idle_check(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check("idle_tx", int'(tx), 1);
            check("idle_busy", int'(busy), 0);
            check("idle_sent", int'(frame_sent), 0);
        end
    endtask

    initial begin
        int n;
        logic prev_fs;

        rst = 1'b1; tx_en = 1'b0;
        BtnL = 1'b1; BtnU = 1'b0; BtnR = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_sent", int'(frame_sent), 0);
        check("rst_cnt", int'(frame_cnt), 0);

        // Frame 1: L=1 U=0 R=1, tx_en from reset release.
        rst = 1'b0; tx_en = 1'b1;
        frame_check(3'b101, -1, -1);
        idle_check(GB * CPB + 1);          // gap plus the single IDLE cycle
        check("cnt_after_f1", int'(frame_cnt), 1);

        // Frame 2: L=0 U=1 R=1, buttons cleared during DATA.
        BtnL = 1'b0; BtnU = 1'b1; BtnR = 1'b1;
        frame_check(3'b110, CPB + 1, -1);
        idle_check(GB * CPB + 1);
        check("cnt_after_f2", int'(frame_cnt), 2);

        // Frame 3: L=1 U=1 R=0, tx_en dropped in the second data bit.
        BtnL = 1'b1; BtnU = 1'b1; BtnR = 1'b0;
        frame_check(3'b011, 2 * CPB + 1, -1 + 0 * 0 + 2 * CPB + 1 == 0 ? -1 : 2 * CPB + 1);
        idle_check(30);
        check("cnt_after_f3", int'(frame_cnt), 3);

        // Reset in the fifth bit period (PARITY when enabled).
        BtnL = 1'b1; BtnU = 1'b0; BtnR = 1'b1;
        tx_en = 1'b1;
        for (int c = 0; c < 4 * CPB + 2; c++) begin
            @(negedge clk);
            check("pre_rst_tx", int'(tx), exp_bit(3'b101, c / CPB));
            check("pre_rst_busy", int'(busy), 1);
        end
        rst = 1'b1; tx_en = 1'b0;
        @(negedge clk);
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_sent", int'(frame_sent), 0);
        check("abort_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        idle_check(10);
        check("abort_cnt_hold", int'(frame_cnt), 0);

        // 256 back-to-back frames: counter wraps.
        tx_en = 1'b1;
        n = 0;
        prev_fs = 1'b0;
        for (int cyc = 0; cyc < 256 * (NB * CPB + GB * CPB + 1) + 50 && n < 256; cyc++) begin
            @(negedge clk);
            if (prev_fs) begin
                n++;
                if (n == 1)   check("wrap_cnt1", int'(frame_cnt), 1);
                if (n == 255) check("wrap_cnt255", int'(frame_cnt), 255);
                if (n == 256) check("wrap_cnt0", int'(frame_cnt), 0);
            end
            prev_fs = frame_sent;
        end
        if (n < 256) check("wrap_frames", n, 256);
        tx_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ctrl_link_tx.md
CTRL_LINK_TX -- requirements
Module: ctrl_link_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit period (minimum 2).
REQ-002 SHALL have parameter GAP_BITS, default 2, meaning idle-high bit periods inserted after each stop bit (minimum 1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port BtnL  input  1  local left button, level, already synchronised.
REQ-006 SHALL have port BtnU  input  1  local jump button, level, already synchronised.
REQ-007 SHALL have port BtnR  input  1  local right button, level, already synchronised.
REQ-008 SHALL have port tx_en  input  1  permits new frames to start while high.
REQ-009 SHALL have port tx  output  1  serial line to remote board; idle high; registered.
REQ-010 SHALL have port busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
REQ-011 SHALL have port frame_sent  output  1  one-cycle pulse on the last stop-bit cycle.
REQ-012 SHALL have port frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, GAP.
REQ-014 IDLE with tx_en=1 SHALL transition to START on the next edge and snapshot {BtnR,BtnU,BtnL} on that same edge.
REQ-015 IDLE with tx_en=0 SHALL remain in IDLE with tx=1.
REQ-016 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads at each bit boundary.
REQ-017 START SHALL drive tx=0.
REQ-018 DATA SHALL send the snapshot LSB-first: L, then U, then R, using a 2-bit index.
REQ-019 PARITY SHALL drive tx = L^U^R of the snapshot (even parity).
REQ-020 STOP SHALL drive tx=1.
REQ-021 frame_sent SHALL pulse and frame_cnt SHALL increment on the final STOP cycle.
REQ-022 GAP SHALL hold tx=1 and busy=0 for GAP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
REQ-023 With tx_en held high, frames SHALL repeat back-to-back: START begins one cycle after GAP ends (the IDLE cycle).
REQ-024 Button changes after the snapshot edge SHALL NOT affect the frame in progress.
REQ-025 Deasserting tx_en mid-frame SHALL NOT abort the frame; the frame and its GAP SHALL complete, then the block SHALL hold IDLE.
REQ-026 tx SHALL be glitch-free: it changes only at bit boundaries.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL enter IDLE with tx=1, busy=0, frame_sent=0, frame_cnt=0, and all counters and the snapshot cleared, from the next cycle.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_sent and no frame_cnt increment.
REQ-029 rst SHALL take priority over tx_en and every state transition.

Configuration
REQ-030 Macro LINK_PARITY_EN defined: the frame SHALL be start, L, U, R, parity, stop (6 bit periods).
REQ-031 Macro LINK_PARITY_EN undefined: the PARITY state SHALL be skipped and DATA SHALL go directly to STOP (5 bit periods); no other timing changes.

Verification (CLKS_PER_BIT=4, GAP_BITS=2, LINK_PARITY_EN defined unless noted)
REQ-032 Stimulus: L=1, U=0, R=1, tx_en=1 from reset release. Required: tx = 0,1,0,1,0,1, each bit 4 cycles; busy high 24 cycles; frame_sent pulses on cycle 24; tx high for 8 cycles; next START follows after one IDLE cycle.
REQ-033 Stimulus: L=0, U=1, R=1 at the snapshot edge, then all buttons changed to 0 during DATA. Required: data bits 0,1,1 and parity 0 are still sent.
REQ-034 Stimulus: tx_en dropped during the second DATA bit. Required: the frame completes, frame_cnt increments by 1, then tx stays 1 and busy stays 0 indefinitely.
REQ-035 Stimulus: rst pulsed for one cycle during PARITY. Required: tx=1 and busy=0 on the next cycle; frame_cnt=0; no frame_sent pulse.
REQ-036 Stimulus: 256 consecutive frames. Required: frame_cnt reads 255 after frame 255 and 0 after frame 256.
REQ-037 Stimulus: LINK_PARITY_EN undefined, L=U=R=1. Required: tx = 0,1,1,1,1 (20 busy cycles), frame_sent pulses on cycle 20.
